// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared registered ALU, with a tag
// pipeline tracking in-flight ops and a credit-limited response FIFO.
module alu_issue_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int OP_W       = 5,
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*OP_W-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0]    req_a,
  input  logic [NUM_REQ*DATA_W-1:0]    req_b,
  output logic [OP_W-1:0]              alu_op,
  output logic [DATA_W-1:0]            alu_in1,
  output logic [DATA_W-1:0]            alu_in2,
  input  logic [DATA_W-1:0]            alu_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [OP_W-1:0]   op_arr [NUM_REQ];
  logic [DATA_W-1:0] a_arr  [NUM_REQ];
  logic [DATA_W-1:0] b_arr  [NUM_REQ];

  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic [ID_W:0]     cand;
  logic              credit_ok, issue, push, pop;

  logic [OP_W-1:0]   alu_op_reg;
  logic [DATA_W-1:0] alu_in1_reg, alu_in2_reg;

  logic [ALU_LAT:0]  tag_valid_reg;
  logic [ID_W-1:0]   tag_id_reg [ALU_LAT+1];

  logic [CNT_W-1:0]  inflight_reg, inflight_next;
  logic [CNT_W-1:0]  fifo_count_reg, fifo_count_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [ID_W-1:0]   id_mem   [FIFO_DEPTH];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign op_arr[gi]    = req_op[gi*OP_W +: OP_W];
    assign a_arr[gi]     = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi]     = req_b[gi*DATA_W +: DATA_W];
    assign req_ready[gi] = issue && (grant_idx == ID_W'(gi));
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  assign credit_ok   = ({1'b0, inflight_reg} + {1'b0, fifo_count_reg}) < (CNT_W+1)'(FIFO_DEPTH);
  // Gating with rst_n keeps grants off while reset is held.
  assign issue       = grant_found && credit_ok && rst_n;
  assign push        = tag_valid_reg[ALU_LAT];
  assign pop         = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      alu_op_reg  <= '0;
      alu_in1_reg <= '0;
      alu_in2_reg <= '0;
    end else if (issue) begin
      rr_ptr_reg  <= rr_ptr_next;
      alu_op_reg  <= op_arr[grant_idx];
      alu_in1_reg <= a_arr[grant_idx];
      alu_in2_reg <= b_arr[grant_idx];
    end
  end

  assign alu_op  = alu_op_reg;
  assign alu_in1 = alu_in1_reg;
  assign alu_in2 = alu_in2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_reg <= '0;
      for (int s = 0; s <= ALU_LAT; s++) tag_id_reg[s] <= '0;
    end else begin
      tag_valid_reg[0] <= issue;
      tag_id_reg[0]    <= grant_idx;
      for (int s = 1; s <= ALU_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

  always_comb begin
    inflight_next   = inflight_reg;
    fifo_count_next = fifo_count_reg;
    if (issue && !push)      inflight_next = inflight_reg + CNT_W'(1);
    else if (!issue && push) inflight_next = inflight_reg - CNT_W'(1);
    if (push && !pop)        fifo_count_next = fifo_count_reg + CNT_W'(1);
    else if (!push && pop)   fifo_count_next = fifo_count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg   <= '0;
      fifo_count_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      inflight_reg   <= inflight_next;
      fifo_count_reg <= fifo_count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  // Storage needs no reset: the head is only exposed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= alu_out;
      id_mem[wr_ptr_reg]   <= tag_id_reg[ALU_LAT];
    end
  end

  assign rsp_valid = (fifo_count_reg != '0);
  assign rsp_data  = rsp_valid ? data_mem[rd_ptr_reg] : '0;
  assign rsp_id    = rsp_valid ? id_mem[rd_ptr_reg] : '0;
  assign busy      = (inflight_reg != '0) || rsp_valid;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: registered ALU stand-in, transaction-level model
// with per-cycle comparison, plus directed scenarios with literal expectations.
module tb_alu_issue_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 32;
  localparam int OP_W       = 5;
  localparam int ALU_LAT    = 1;
  localparam int FIFO_DEPTH = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op = '0;
  logic [NUM_REQ*DATA_W-1:0] req_a = '0;
  logic [NUM_REQ*DATA_W-1:0] req_b = '0;
  logic [OP_W-1:0]           alu_op;
  logic [DATA_W-1:0]         alu_in1, alu_in2;
  logic [DATA_W-1:0]         alu_out = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [1:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W),
    .ALU_LAT(ALU_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // Single-cycle registered ALU stand-in.
  always @(posedge clk) alu_out <= alu_f(alu_op, alu_in1, alu_in2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: outstanding = issued - popped gives the credit check;
  // each issue queues its expected result, visible ALU_LAT+1 edges later.
  typedef struct {
    logic [1:0]        id;
    logic [DATA_W-1:0] data;
    int                due;
  } rsp_t;

  rsp_t              mq[$];
  rsp_t              ent;
  int                cyc = 0;
  int                outstanding = 0;
  int                m_rr = 0;
  logic [OP_W-1:0]   m_op = '0;
  logic [DATA_W-1:0] m_in1 = '0, m_in2 = '0;
  int                e_grant = -1;
  logic              e_rsp_valid = 1'b0;
  logic [NUM_REQ-1:0] e_ready;
  int                j;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      outstanding = 0;
      m_rr  = 0;
      m_op  = '0;
      m_in1 = '0;
      m_in2 = '0;
    end else begin
      cyc = cyc + 1;
      if (e_rsp_valid && rsp_ready) begin
        void'(mq.pop_front());
        outstanding--;
      end
      if (e_grant >= 0) begin
        m_op  = req_op[e_grant*OP_W +: OP_W];
        m_in1 = req_a[e_grant*DATA_W +: DATA_W];
        m_in2 = req_b[e_grant*DATA_W +: DATA_W];
        ent.id   = 2'(e_grant);
        ent.data = alu_f(m_op, m_in1, m_in2);
        ent.due  = cyc + ALU_LAT + 1;
        mq.push_back(ent);
        outstanding++;
        m_rr = (e_grant + 1) % NUM_REQ;
      end
    end
  end

  always @(negedge clk) begin
    e_grant = -1;
    if (rst_n && outstanding < FIFO_DEPTH) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (m_rr + k) % NUM_REQ;
        if (e_grant < 0 && req_valid[j]) e_grant = j;
      end
    end
    e_ready = '0;
    if (e_grant >= 0) e_ready[e_grant] = 1'b1;
    e_rsp_valid = 1'b0;
    if (rst_n && mq.size() > 0) e_rsp_valid = (mq[0].due <= cyc);
    chk("req_ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_rsp_valid);
    chk("busy", busy, outstanding != 0);
    chk("alu_op", alu_op, m_op);
    chk("alu_in1", alu_in1, m_in1);
    chk("alu_in2", alu_in2, m_in2);
    chk("no_overflow", outstanding <= FIFO_DEPTH, 1);
    if (e_rsp_valid) begin
      chk("rsp_id", rsp_id, mq[0].id);
      chk("rsp_data", rsp_data, mq[0].data);
    end
  end

  int grant_log[$];
  int rsp_log[$];

  always @(negedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) grant_log.push_back(k);
    if (rst_n && rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));
  end

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OP_W-1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_op[i*OP_W +: OP_W]     = op;
    req_a[i*DATA_W +: DATA_W]  = a;
    req_b[i*DATA_W +: DATA_W]  = b;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 50) begin
      cyc_end();
      n++;
    end
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with every requester asking.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(i), 32'(100 + i), 32'(7 + i));
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_in2", alu_in2, 0);
    cyc_end();
    rst_n = 1'b1;
    req_valid = '0;

    // Single request: 3 + 4.
    set_req(0, 5'h0, 32'd3, 32'd4);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_grant", req_ready, 4'b0001);
    cyc_end();
    req_valid = '0;
    @(negedge clk);
    chk("single_in1", alu_in1, 3);
    chk("single_in2", alu_in2, 4);
    chk("single_not_yet_1", rsp_valid, 0);
    cyc_end();
    @(negedge clk);
    chk("single_not_yet_2", rsp_valid, 0);
    cyc_end();
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 0);
    chk("single_rsp_data", rsp_data, 7);
    cyc_end();
    drain();

    // Move the pointer back to 0, then full contention.
    req_valid = 4'b1000;
    cyc_end();
    req_valid = '0;
    drain();
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 5'(i), 32'h1000 * (i + 1) + i, 32'h11 * i);
    grant_log.delete();
    rsp_log.delete();
    req_valid = 4'hF;
    repeat (12) cyc_end();
    req_valid = '0;
    drain();
    chk("contend_grant_count", grant_log.size(), 12);
    chk("contend_rsp_count", rsp_log.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk("contend_grant_order", grant_log[k], k % 4);
      chk("contend_rsp_order", rsp_log[k], k % 4);
    end

    // Backpressure: four credits, then stall until a pop.
    rsp_ready = 1'b0;
    grant_log.delete();
    req_valid = 4'hF;
    repeat (10) cyc_end();
    chk("bp_issue_count", grant_log.size(), 4);
    chk("bp_fifo_full_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hold_until_pop", req_ready, 4'b0000);
    cyc_end();
    @(negedge clk);
    chk("bp_resume", req_ready != 0, 1);
    chk("bp_resume_grant", req_ready, 4'b0001);
    cyc_end();
    req_valid = '0;
    drain();

    // Fairness from rr_ptr=2 with requesters 1 and 3.
    req_valid = 4'b0010;
    cyc_end();
    req_valid = '0;
    drain();
    grant_log.delete();
    req_valid = 4'b1010;
    repeat (3) cyc_end();
    req_valid = '0;
    chk("fair_count", grant_log.size(), 3);
    chk("fair_0", grant_log[0], 3);
    chk("fair_1", grant_log[1], 1);
    chk("fair_2", grant_log[2], 3);
    drain();

    // Reset with ops in flight and a buffered result.
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    repeat (2) cyc_end();
    req_valid = '0;
    cyc_end();
    chk("midrst_busy_before", busy, 1);
    chk("midrst_valid_before", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    req_valid = 4'b0110;
    #1;
    chk("midrst_no_grant", req_ready, 4'b0000);
    cyc_end();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_first_grant", req_ready, 4'b0010);
    cyc_end();
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
